// File: rtl/chunked_serial_adder_if.sv
// Start/busy/done bundle for chunked_serial_adder.
// The overflow wire exists only when OVERFLOW_DETECT_EN is defined.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
`ifdef OVERFLOW_DETECT_EN
  logic             overflow;
`endif

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, result, c_out
`ifdef OVERFLOW_DETECT_EN
    , input overflow
`endif
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, result, c_out
`ifdef OVERFLOW_DETECT_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/sub reusing one CHUNK-bit slice, LS chunk first.
// Optional signed overflow output: define OVERFLOW_DETECT_EN.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                  clk,
  input logic                  rst,
  chunked_serial_adder_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, c_out_q, done_q;
`ifdef OVERFLOW_DETECT_EN
  logic             ovf_q;
`endif

  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             cy;
  logic             last;
  logic             accept;

  assign accept = (state_q == IDLE) && bus.start;
  assign last   = (k_q == KW'(N - 1));
  assign a_ch   = a_q[k_q*CHUNK +: CHUNK];
  assign b_ch   = b_q[k_q*CHUNK +: CHUNK];
  assign {cy, s_ch} = {1'b0, a_ch} + {1'b0, b_ch}
                    + (CHUNK+1)'(carry_q);

  // merged view so the final chunk reaches result on the same edge
  always_comb begin
    sum_d = sum_q;
    sum_d[k_q*CHUNK +: CHUNK] = s_ch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (last)      state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state_q == RUN);
    bus.done   = done_q;
    bus.result = result_q;
    bus.c_out  = c_out_q;
`ifdef OVERFLOW_DETECT_EN
    bus.overflow = ovf_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.sub ? ~bus.b : bus.b;
        carry_q <= bus.sub ? ~bus.c_in : bus.c_in;
        k_q     <= '0;
      end else if (state_q == RUN) begin
        sum_q   <= sum_d;
        carry_q <= cy;
        k_q     <= last ? '0 : k_q + 1'b1;
        if (last) begin
          result_q <= sum_d;
          c_out_q  <= cy;
          done_q   <= 1'b1;
`ifdef OVERFLOW_DETECT_EN
          // carry into MSB recovered as a ^ b ^ sum at that bit
          ovf_q    <= a_ch[CHUNK-1] ^ b_ch[CHUNK-1]
                    ^ s_ch[CHUNK-1] ^ cy;
`endif
        end
      end
    end
  end
endmodule
